apb_slave: RTL and testbench
============================

APB_SLAVE -- requirements
Module: apb_slave

Interface
REQ-001 Parameters, one per line (name, default, meaning):
  - BASE_ADDR, 32'hDEAD_CAE0, base of the 32-byte register window.
  - WAIT_CYCLES, 2, wait states inserted before pready_o (0..15).
  - ID_VALUE, 32'hA9B0_0001, read-only contents of register 0.
REQ-002 Ports, one per line (name, direction, width, meaning):
  - clk, in, 1, sole clock, rising edge.
  - reset_n, in, 1, asynchronous active-low reset.
  - psel_i, in, 1, APB select.
  - penable_i, in, 1, APB access phase.
  - paddr_i, in, 32, byte address.
  - pwrite_i, in, 1, 1 = write, 0 = read.
  - pwdata_i, in, 32, write data.
  - pready_o, out, 1, transfer complete.
  - prdata_o, out, 32, read data, valid when pready_o = 1.
  - pslverr_o, out, 1, error response, valid when pready_o = 1.
REQ-003 The block SHALL have one clock (clk) and an asynchronous, active-low reset (reset_n).

Function
REQ-004 The block SHALL implement an APB3 completer with eight 32-bit registers, REG0..REG7.
REQ-005 Address decode SHALL be as follows:
  - Hit when paddr_i[31:5] == BASE_ADDR[31:5].
  - Register index = paddr_i[4:2]; paddr_i[1:0] is ignored.
  - Example: 0xDEAD_CAFE maps to REG7.
REQ-006 The FSM SHALL have two states, ST_IDLE and ST_ACCESS.
REQ-007 In ST_IDLE, psel_i=1 with penable_i=0 (setup phase) SHALL:
  - move the FSM to ST_ACCESS on the next edge;
  - load the wait counter with WAIT_CYCLES.
REQ-008 In ST_ACCESS with psel_i=1, penable_i=1 and the wait counter nonzero, the counter SHALL decrement by one per cycle and pready_o SHALL be 0.
REQ-009 pready_o SHALL be 1 when:
  - state is ST_ACCESS, the wait counter is 0, and psel_i and penable_i are both 1;
  - the transfer therefore completes WAIT_CYCLES+1 cycles after the setup cycle;
  - with WAIT_CYCLES=0 there are no wait states.
REQ-010 On the completing cycle the FSM SHALL return to ST_IDLE.
REQ-011 A setup phase in the cycle immediately after completion SHALL be accepted (back-to-back transfers, no idle gap).
REQ-012 A write SHALL commit pwdata_i to the indexed register on the completing edge only, and only when pslverr_o=0.
REQ-013 A read SHALL present on prdata_o, combinationally during the completing cycle:
  - REG0 returns ID_VALUE;
  - REG1..REG7 return their stored value;
  - prdata_o SHALL be 0 in every other cycle.
REQ-014 pslverr_o SHALL be 1 on the completing cycle for an address miss or a write to REG0. Errored writes SHALL NOT modify state, and errored reads SHALL return 0.
REQ-015 If psel_i drops while in ST_ACCESS (protocol abort), the FSM SHALL return to ST_IDLE next cycle with no register update and no pready_o.
REQ-016 penable_i=1 while in ST_IDLE SHALL be ignored (no transfer starts).
REQ-017 pready_o and pslverr_o SHALL be 0 whenever psel_i=0.

Reset
REQ-018 Asserting reset_n=0 SHALL immediately, without waiting for a clock edge:
  - force the FSM to ST_IDLE;
  - clear the wait counter and REG1..REG7 to 0;
  - drive pready_o=0, pslverr_o=0 and prdata_o=0.
REQ-019 Reset asserted mid-transfer SHALL abort the transfer with no write commit. The first setup phase after deassertion SHALL be handled normally.

Structure
REQ-020 Package apb_pkg SHALL hold:
  - the state enum apb_slv_state_t {ST_IDLE, ST_ACCESS};
  - the register count (8);
  - the default ID constant.
REQ-021 The register array and read mux SHALL live in one sub-module, apb_slave_regs. The FSM, wait counter and decode SHALL stay in apb_slave.

Verification
REQ-022 Write then read, WAIT_CYCLES=2:
  - write 0x0000_0041 to 0xDEAD_CAFE, then read it back;
  - pready_o rises 3 cycles after each setup cycle;
  - the read returns 0x0000_0041 with pslverr_o=0.
REQ-023 Zero wait states, WAIT_CYCLES=0:
  - read 0xDEAD_CAE0;
  - pready_o=1 in the first access cycle, prdata_o=0xA9B0_0001.
REQ-024 Errors:
  - write 0x1234 to 0xDEAD_CAE0, then read it back: pslverr_o=1 on the write, the read still returns 0xA9B0_0001;
  - read 0x0000_0004: pslverr_o=1, prdata_o=0.
REQ-025 Back-to-back:
  - write 5 to REG3, with the next setup in the cycle right after pready_o, reading REG3;
  - the read returns 5 and no idle cycle is needed.
REQ-026 Abort: drop psel_i after one wait cycle of a write of 0xFF to REG2; a later read of REG2 returns 0.
REQ-027 Reset mid-transfer: pulse reset_n low during a wait cycle of a write to REG4; pready_o=0 immediately and REG4 reads 0 afterwards.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and constants for the APB register slave.
package apb_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } apb_slv_state_t;

  localparam int unsigned NUM_REGS  = 8;
  localparam int unsigned IDX_W     = 3;
  localparam logic [31:0] DEFAULT_ID = 32'hA9B0_0001;

endpackage

// File: rtl/apb_slave_regs.sv
// Register file for the APB slave: REG0 is a read-only ID, REG1..REG7 are read/write.
module apb_slave_regs
  import apb_pkg::*;
#(
  parameter logic [31:0] ID_VALUE = DEFAULT_ID
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [31:0]      wr_data_i,
  output logic [31:0]      rd_data_o
);

  logic [31:0] regs_q [NUM_REGS];
  logic [31:0] regs_d [NUM_REGS];

  // Next register contents: only the indexed entry changes on a qualified write; REG0 is never stored.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (wr_en_i && (idx_i != '0)) begin
      regs_d[idx_i] = wr_data_i;
    end
  end

  // Register storage, cleared immediately by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Read mux: index 0 returns the fixed ID, others the stored value.
  always_comb begin
    rd_data_o = regs_q[idx_i];
    if (idx_i == '0) begin
      rd_data_o = ID_VALUE;
    end
  end

endmodule

// File: rtl/apb_slave.sv
// APB3 completer with a 32-byte window of eight registers and programmable wait states.
module apb_slave
  import apb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'hDEAD_CAE0,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] ID_VALUE    = DEFAULT_ID
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        psel_i,
  input  logic        penable_i,
  input  logic [31:0] paddr_i,
  input  logic        pwrite_i,
  input  logic [31:0] pwdata_i,
  output logic        pready_o,
  output logic [31:0] prdata_o,
  output logic        pslverr_o
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  apb_slv_state_t   state_q, state_d;
  logic [3:0]       wait_cnt_q, wait_cnt_d;
  logic             addr_hit;
  logic [IDX_W-1:0] reg_idx;
  logic             access_err;
  logic             complete;
  logic             reg_wr_en;
  logic [31:0]      reg_rd_data;
  logic             unused_addr_bits;

  assign addr_hit         = (paddr_i[31:5] == BASE_ADDR[31:5]);
  assign reg_idx          = paddr_i[4:2];
  assign unused_addr_bits = ^paddr_i[1:0];
  assign access_err       = !addr_hit || (pwrite_i && (reg_idx == '0));
  assign complete         = (state_q == ST_ACCESS) && (wait_cnt_q == '0) && psel_i && penable_i;
  assign reg_wr_en        = complete && pwrite_i && !access_err;

  // State and wait counter registers, forced idle and cleared by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Next-state logic: setup starts an access, wait states count down, deselect aborts.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (psel_i && !penable_i) begin
          state_d    = ST_ACCESS;
          wait_cnt_d = WAIT_INIT;
        end
      end
      ST_ACCESS: begin
        if (!psel_i) begin
          state_d    = ST_IDLE;
          wait_cnt_d = '0;
        end else if (penable_i) begin
          if (wait_cnt_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            wait_cnt_d = wait_cnt_q - 4'd1;
          end
        end
      end
      default: begin
        state_d    = ST_IDLE;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Response outputs: only meaningful on the completing cycle, zero otherwise.
  always_comb begin
    pready_o  = complete;
    pslverr_o = complete && access_err;
    prdata_o  = '0;
    if (complete && !pwrite_i && !access_err) begin
      prdata_o = reg_rd_data;
    end
  end

  apb_slave_regs #(
    .ID_VALUE (ID_VALUE)
  ) u_regs (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_en_i   (reg_wr_en),
    .idx_i     (reg_idx),
    .wr_data_i (pwdata_i),
    .rd_data_o (reg_rd_data)
  );

endmodule

// File: tb/tb_apb_slave.sv
// Self-checking bench for apb_slave: a 2-wait-state instance and a zero-wait instance.
module tb_apb_slave;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        psel_a, psel_b, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic        pready_a, pslverr_a, pready_b, pslverr_b;
  logic [31:0] prdata_a, prdata_b;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          latency;
  } exp_t;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[9];

  apb_slave #(
    .BASE_ADDR   (32'hDEAD_CAE0),
    .WAIT_CYCLES (2),
    .ID_VALUE    (32'hA9B0_0001)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .psel_i    (psel_a),
    .penable_i (penable),
    .paddr_i   (paddr),
    .pwrite_i  (pwrite),
    .pwdata_i  (pwdata),
    .pready_o  (pready_a),
    .prdata_o  (prdata_a),
    .pslverr_o (pslverr_a)
  );

  apb_slave #(
    .BASE_ADDR   (32'hDEAD_CAE0),
    .WAIT_CYCLES (0),
    .ID_VALUE    (32'hA9B0_0001)
  ) dut0 (
    .clk       (clk),
    .reset_n   (reset_n),
    .psel_i    (psel_b),
    .penable_i (penable),
    .paddr_i   (paddr),
    .pwrite_i  (pwrite),
    .pwdata_i  (pwdata),
    .pready_o  (pready_b),
    .prdata_o  (prdata_b),
    .pslverr_o (pslverr_b)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One full APB transfer; expectation queued at setup, popped when pready is seen.
  task automatic applyStimulus(input bit use_b, input logic wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic exp_err,
                               input logic [31:0] exp_rdata, input int exp_lat);
    exp_t e;
    int   cyc;
    bit   done;
    logic rdy, serr;
    logic [31:0] rd;
    @(negedge clk);
    psel_a  = !use_b;
    psel_b  = use_b;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = wdata;
    e.err = exp_err;
    e.rdata = exp_rdata;
    e.latency = exp_lat;
    sb.push_back(e);
    #1;
    checkOutput("setup_pready", {31'd0, (use_b ? pready_b : pready_a)}, 32'd0);
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < 20) begin
      @(negedge clk);
      penable = 1'b1;
      cyc++;
      #1;
      rdy  = use_b ? pready_b : pready_a;
      serr = use_b ? pslverr_b : pslverr_a;
      rd   = use_b ? prdata_b : prdata_a;
      if (rdy) begin
        done = 1'b1;
        e = sb.pop_front();
        checkOutput("latency", 32'(cyc), 32'(e.latency));
        checkOutput("pslverr", {31'd0, serr}, {31'd0, e.err});
        checkOutput("prdata", rd, e.rdata);
      end else begin
        checkOutput("wait_prdata", rd, 32'd0);
      end
    end
    if (!done) begin
      void'(sb.pop_front());
      checks++;
      errors++;
      $display("[TB] FAIL timeout: got no pready after %0d cycles expected %0d", cyc, exp_lat);
    end
  endtask

  task automatic idleBus();
    @(negedge clk);
    psel_a  = 1'b0;
    psel_b  = 1'b0;
    penable = 1'b0;
    #1;
    checkOutput("idle_pready", {31'd0, pready_a}, 32'd0);
    checkOutput("idle_pslverr", {31'd0, pslverr_a}, 32'd0);
    checkOutput("idle_prdata", prdata_a, 32'd0);
  endtask

  initial begin
    vecs[0] = '{1'b1, 32'hDEAD_CAFE, 32'h0000_0041, 1'b0, 32'h0};
    vecs[1] = '{1'b0, 32'hDEAD_CAFE, 32'h0,         1'b0, 32'h0000_0041};
    vecs[2] = '{1'b1, 32'hDEAD_CAE0, 32'h0000_1234, 1'b1, 32'h0};
    vecs[3] = '{1'b0, 32'hDEAD_CAE0, 32'h0,         1'b0, 32'hA9B0_0001};
    vecs[4] = '{1'b0, 32'h0000_0004, 32'h0,         1'b1, 32'h0};
    vecs[5] = '{1'b1, 32'h0000_0004, 32'h0000_0055, 1'b1, 32'h0};
    vecs[6] = '{1'b1, 32'hDEAD_CAF5, 32'h1234_5678, 1'b0, 32'h0};
    vecs[7] = '{1'b0, 32'hDEAD_CAF4, 32'h0,         1'b0, 32'h1234_5678};
    vecs[8] = '{1'b0, 32'hDEAD_CB00, 32'h0,         1'b1, 32'h0};

    reset_n = 1'b0;
    psel_a  = 1'b0;
    psel_b  = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = '0;
    pwdata  = '0;
    #1;
    checkOutput("reset_pready", {31'd0, pready_a}, 32'd0);
    checkOutput("reset_pslverr", {31'd0, pslverr_a}, 32'd0);
    checkOutput("reset_prdata", prdata_a, 32'd0);
    #21;
    reset_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b0, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].err, vecs[i].rdata, 3);
      idleBus();
    end

    // Back-to-back: read setup directly follows the write's completing cycle.
    applyStimulus(1'b0, 1'b1, 32'hDEAD_CAEC, 32'd5, 1'b0, 32'h0, 3);
    applyStimulus(1'b0, 1'b0, 32'hDEAD_CAEC, 32'h0, 1'b0, 32'd5, 3);
    idleBus();

    // Zero-wait instance.
    applyStimulus(1'b1, 1'b0, 32'hDEAD_CAE0, 32'h0, 1'b0, 32'hA9B0_0001, 1);
    applyStimulus(1'b1, 1'b1, 32'hDEAD_CAE4, 32'hCAFE_0001, 1'b0, 32'h0, 1);
    applyStimulus(1'b1, 1'b0, 32'hDEAD_CAE4, 32'h0, 1'b0, 32'hCAFE_0001, 1);
    idleBus();

    // Abort: deselect after one wait cycle of a write to REG2.
    @(negedge clk);
    psel_a = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'hDEAD_CAE8; pwdata = 32'hFF;
    @(negedge clk);
    penable = 1'b1;
    #1 checkOutput("abort_wait_pready", {31'd0, pready_a}, 32'd0);
    @(negedge clk);
    psel_a = 1'b0; penable = 1'b0;
    #1 checkOutput("abort_pready", {31'd0, pready_a}, 32'd0);
    idleBus();
    applyStimulus(1'b0, 1'b0, 32'hDEAD_CAE8, 32'h0, 1'b0, 32'h0, 3);
    idleBus();

    // penable in idle without a setup phase must not start a transfer.
    @(negedge clk);
    psel_a = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 32'hDEAD_CAF8; pwdata = 32'h77;
    #1 checkOutput("idle_en_pready0", {31'd0, pready_a}, 32'd0);
    @(negedge clk);
    #1 checkOutput("idle_en_pready1", {31'd0, pready_a}, 32'd0);
    idleBus();
    applyStimulus(1'b0, 1'b0, 32'hDEAD_CAF8, 32'h0, 1'b0, 32'h0, 3);
    @(negedge clk);
    psel_a = 1'b0; penable = 1'b1;
    #1 checkOutput("nosel_pready", {31'd0, pready_a}, 32'd0);
    checkOutput("nosel_pslverr", {31'd0, pslverr_a}, 32'd0);
    idleBus();

    // Reset pulsed during a wait cycle of a write to REG4.
    @(negedge clk);
    psel_a = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'hDEAD_CAF0; pwdata = 32'hAB;
    @(negedge clk);
    penable = 1'b1;
    #1 checkOutput("rst_wait_pready", {31'd0, pready_a}, 32'd0);
    #1 reset_n = 1'b0;
    #1 checkOutput("rst_async_pready", {31'd0, pready_a}, 32'd0);
    checkOutput("rst_async_prdata", prdata_a, 32'd0);
    @(negedge clk);
    psel_a = 1'b0; penable = 1'b0;
    #2 reset_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'hDEAD_CAF0, 32'h0, 1'b0, 32'h0, 3);
    applyStimulus(1'b0, 1'b0, 32'hDEAD_CAFC, 32'h0, 1'b0, 32'h0, 3);
    applyStimulus(1'b0, 1'b0, 32'hDEAD_CAE0, 32'h0, 1'b0, 32'hA9B0_0001, 3);
    idleBus();

    checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
